// File: rtl/act_row_packer_pkg.sv
// Shared widths and types for the activation row packer and its
// companions on the activation buffer write path.
package act_row_packer_pkg;

    localparam int IF_WIDTH        = 16;
    localparam int DATA_WIDTH      = 8;
    localparam int ADDR_WIDTH      = 8;
    localparam int ROW_CNT_WIDTH   = ADDR_WIDTH + 1;
    localparam int LANE_IDX_WIDTH  = $clog2(IF_WIDTH);
    localparam int ACT_INDEX_WIDTH = LANE_IDX_WIDTH;
    localparam int ROW_WIDTH       = IF_WIDTH * DATA_WIDTH;

    typedef logic [DATA_WIDTH-1:0]     act_t;
    typedef logic [IF_WIDTH-1:0]       mask_t;
    typedef logic [ROW_WIDTH-1:0]      row_t;
    typedef logic [LANE_IDX_WIDTH:0]   lane_count_t;
    typedef logic [ROW_CNT_WIDTH-1:0]  row_cnt_t;

endpackage

// File: rtl/act_row_packer_if.sv
// Stream-in and sparse-write-out signal bundle of the activation row packer.
interface act_row_packer_if;
    import act_row_packer_pkg::*;

    logic        start;
    row_cnt_t    row_num;
    logic        in_valid;
    act_t        in_data;
    logic        in_ready;
    logic        wr_req_act_flag;
    mask_t       wr_data_act_flag;
    mask_t       wr_req_act;
    row_t        wr_data_act;
    lane_count_t row_val_num;
    logic        zero_row;
    logic        busy;
    logic        done;

    modport master (
        output start, row_num, in_valid, in_data,
        input  in_ready, wr_req_act_flag, wr_data_act_flag, wr_req_act,
               wr_data_act, row_val_num, zero_row, busy, done
    );

    modport slave (
        input  start, row_num, in_valid, in_data,
        output in_ready, wr_req_act_flag, wr_data_act_flag, wr_req_act,
               wr_data_act, row_val_num, zero_row, busy, done
    );

endinterface

// File: rtl/act_row_packer_row_nz_mask.sv
// Nonzero-lane mask and its popcount for one packed row; purely combinational,
// shared with the weight-side packer.
module row_nz_mask
    import act_row_packer_pkg::*;
(
    input  row_t        row,
    output mask_t       mask,
    output lane_count_t count
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned, which would infer a latch.
        mask  = '0;
        count = '0;
        for (int i = 0; i < IF_WIDTH; i++) begin
            mask[i] = |row[i*DATA_WIDTH +: DATA_WIDTH];
            count   = count + {{LANE_IDX_WIDTH{1'b0}}, mask[i]};
        end
    end

endmodule

// File: rtl/act_row_packer.sv
// Packs a dense byte stream into rows and emits one flag write plus
// per-column writes for the nonzero lanes of each row.
module act_row_packer
    import act_row_packer_pkg::*;
(
    input logic            clk,
    input logic            reset,
    act_row_packer_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;
    localparam logic [1:0] ST_FIN     = 2'd3;

    logic [1:0]                state;
    logic [LANE_IDX_WIDTH-1:0] lane_cnt;
    row_cnt_t                  row_cnt;
    row_cnt_t                  row_target;
    row_t                      row_q;
    mask_t                     mask;
    lane_count_t               count;
    row_cnt_t                  row_cnt_next;
    logic                      last_lane;
    logic                      emit;

    row_nz_mask u_mask (
        .row   (row_q),
        .mask  (mask),
        .count (count)
    );

    assign row_cnt_next = row_cnt + ROW_CNT_WIDTH'(1);
    assign last_lane    = (lane_cnt == LANE_IDX_WIDTH'(IF_WIDTH - 1));
    assign emit         = (state == ST_EMIT);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            lane_cnt   <= '0;
            row_cnt    <= '0;
            row_target <= '0;
            row_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.row_num != '0) begin
                            row_target <= bus.row_num;
                            row_cnt    <= '0;
                            lane_cnt   <= '0;
                            state      <= ST_COLLECT;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (bus.in_valid) begin
                        row_q[lane_cnt*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
                        // The lane counter wraps to 0 naturally after the last lane.
                        lane_cnt <= lane_cnt + LANE_IDX_WIDTH'(1);
                        if (last_lane) begin
                            state <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    row_cnt <= row_cnt_next;
                    state   <= (row_cnt_next == row_target) ? ST_FIN : ST_COLLECT;
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write-side outputs are decoded from state so they are quiet outside EMIT.
    assign bus.in_ready         = (state == ST_COLLECT);
    assign bus.busy             = (state == ST_COLLECT) || emit;
    assign bus.done             = (state == ST_FIN);
    assign bus.wr_req_act_flag  = emit;
    assign bus.wr_data_act_flag = emit ? mask : '0;
    assign bus.wr_req_act       = emit ? mask : '0;
    assign bus.wr_data_act      = emit ? row_q : '0;
    assign bus.row_val_num      = emit ? count : '0;
    assign bus.zero_row         = emit && (mask == '0);

endmodule
